// File: rtl/ps_pkg.sv
// Shared types and constants for the AXI-Lite to parameter-store request bridge.
// Request records are packed MSB-first as {we, addr, data}.
package ps_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/ps_req_fifo.sv
// First-word-fall-through request FIFO; the head entry is visible on dout_o whenever empty_o is low.
// A push while full is dropped, so the caller must gate pushes with full_o.
module ps_req_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/axil_ps_bridge.sv
// AXI-Lite slave that merges posted writes and single-outstanding reads into one in-order PS request stream.
// AW+W or AR to ps_req_valid: 2 cycles; ps_rsp to rvalid: 1 cycle; a full FIFO or an unaccepted B holds the AXI inputs.
module axil_ps_bridge
    import ps_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  wavalid,
    output logic                  waready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  ps_req_valid,
    input  logic                  ps_req_ready,
    output logic                  ps_req_we,
    output logic [ADDR_WIDTH-1:0] ps_req_addr,
    output logic [DATA_WIDTH-1:0] ps_req_data,
    input  logic                  ps_rsp_valid,
    output logic                  ps_rsp_ready,
    input  logic [DATA_WIDTH-1:0] ps_rsp_data
);
    localparam int REQ_W = req_width(ADDR_WIDTH, DATA_WIDTH);

    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q, rdata_q;
    logic                  rd_out_q, rd_out_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    grant_e                last_grant_q, last_grant_d;

    logic             aw_hs, w_hs, ar_hs, rsp_hs, r_hs;
    logic             fifo_full, fifo_empty, wr_elig, rd_elig, grant_wr, grant_rd;
    logic [REQ_W-1:0] push_dat, head_dat;

    assign waready      = !aw_held_q;
    assign wready       = !w_held_q;
    assign arready      = !ar_held_q && !rd_out_q;
    assign bvalid       = bvalid_q;
    assign bresp        = RESP_OKAY;
    assign rvalid       = rvalid_q;
    assign rresp        = RESP_OKAY;
    assign rdata        = rdata_q;
    assign ps_rsp_ready = !rvalid_q;
    assign ps_req_valid = !fifo_empty;
    assign {ps_req_we, ps_req_addr, ps_req_data} = head_dat;

    assign aw_hs  = wavalid && waready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    // Responses arriving with no read outstanding are dropped.
    assign rsp_hs = ps_rsp_valid && ps_rsp_ready && rd_out_q;
    assign r_hs   = rvalid_q && rready;

    assign wr_elig = aw_held_q && w_held_q && !fifo_full && (!bvalid_q || bready);
    assign rd_elig = ar_held_q && !fifo_full;

    always_comb begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
        if (wr_elig && rd_elig) begin
            grant_wr = (last_grant_q == GRANT_READ);
            grant_rd = (last_grant_q == GRANT_WRITE);
        end
    end

    assign push_dat = grant_wr ? {1'b1, aw_addr_q, w_data_q}
                               : {1'b0, ar_addr_q, {DATA_WIDTH{1'b0}}};

    always_comb begin
        aw_held_d    = (aw_held_q && !grant_wr) || aw_hs;
        w_held_d     = (w_held_q && !grant_wr) || w_hs;
        ar_held_d    = (ar_held_q && !grant_rd) || ar_hs;
        rd_out_d     = (rd_out_q && !r_hs) || ar_hs;
        bvalid_d     = grant_wr || (bvalid_q && !bready);
        rvalid_d     = rsp_hs || (rvalid_q && !rready);
        last_grant_d = last_grant_q;
        if (grant_wr) last_grant_d = GRANT_WRITE;
        if (grant_rd) last_grant_d = GRANT_READ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            ar_held_q    <= 1'b0;
            rd_out_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            last_grant_q <= GRANT_READ;
            aw_addr_q    <= '0;
            ar_addr_q    <= '0;
            w_data_q     <= '0;
            rdata_q      <= '0;
        end else begin
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            ar_held_q    <= ar_held_d;
            rd_out_q     <= rd_out_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            last_grant_q <= last_grant_d;
            if (aw_hs)  aw_addr_q <= waddr;
            if (ar_hs)  ar_addr_q <= raddr;
            if (w_hs)   w_data_q  <= wdata;
            if (rsp_hs) rdata_q   <= ps_rsp_data;
        end
    end

    ps_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (grant_wr || grant_rd),
        .din_i   (push_dat),
        .pop_i   (ps_req_valid && ps_req_ready),
        .dout_o  (head_dat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_axil_ps_bridge.sv
// Directed testbench for axil_ps_bridge: each task drives one scenario and checks hand-computed values.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_axil_ps_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  waddr = '0, raddr = '0;
    logic        wavalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic [31:0] wdata = '0, ps_rsp_data = '0;
    logic        bready = 1'b1, rready = 1'b0, ps_req_ready = 1'b1, ps_rsp_valid = 1'b0;
    logic        waready, wready, bvalid, arready, rvalid, ps_req_valid, ps_req_we, ps_rsp_ready;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ps_req_data;
    logic [3:0]  ps_req_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_ps_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .waddr(waddr), .wavalid(wavalid), .waready(waready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .raddr(raddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .ps_req_valid(ps_req_valid), .ps_req_ready(ps_req_ready), .ps_req_we(ps_req_we),
        .ps_req_addr(ps_req_addr), .ps_req_data(ps_req_data),
        .ps_rsp_valid(ps_rsp_valid), .ps_rsp_ready(ps_rsp_ready), .ps_rsp_data(ps_rsp_data)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        step(2);
        #3 rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({waready, wready, arready, bvalid, rvalid, ps_req_valid, ps_rsp_ready} !== 7'b1110001) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1110001",
                     {waready, wready, arready, bvalid, rvalid, ps_req_valid, ps_rsp_ready});
        end
        checks++;
        if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            failures++;
            $display("FAIL reset_data got rdata=%h bresp=%b rresp=%b exp 0/00/00", rdata, bresp, rresp);
        end
    endtask

    task automatic test_write_same_cycle();
        waddr = 4'h4; wdata = 32'hDEADBEEF; wavalid = 1'b1; wvalid = 1'b1;
        step();
        wavalid = 1'b0; wvalid = 1'b0;
        checks++;
        if ({waready, wready, ps_req_valid, bvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL wr_cycle1 got=%b exp=0000", {waready, wready, ps_req_valid, bvalid});
        end
        step();
        checks++;
        if ({ps_req_valid, ps_req_we, ps_req_addr, ps_req_data} !== {1'b1, 1'b1, 4'h4, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL wr_req got v=%b we=%b a=%h d=%h exp 1 1 4 deadbeef",
                     ps_req_valid, ps_req_we, ps_req_addr, ps_req_data);
        end
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || waready !== 1'b1) begin
            failures++;
            $display("FAIL wr_bvalid got b=%b resp=%b awrdy=%b exp 1 00 1", bvalid, bresp, waready);
        end
        step();
        checks++;
        if (ps_req_valid !== 1'b0 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_drain got v=%b b=%b exp 0 0", ps_req_valid, bvalid);
        end
    endtask

    task automatic test_w_before_aw();
        wdata = 32'h12; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || waready !== 1'b1) begin
            failures++;
            $display("FAIL w_held got wready=%b waready=%b exp 0 1", wready, waready);
        end
        step(2);
        checks++;
        if (wready !== 1'b0 || ps_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL w_wait got wready=%b v=%b exp 0 0", wready, ps_req_valid);
        end
        waddr = 4'h8; wavalid = 1'b1;
        step();
        wavalid = 1'b0;
        checks++;
        if (ps_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL w_early_latency got v=%b exp 0", ps_req_valid);
        end
        step();
        checks++;
        if ({ps_req_valid, ps_req_we, ps_req_addr, ps_req_data} !== {1'b1, 1'b1, 4'h8, 32'h12}) begin
            failures++;
            $display("FAIL w_early_req got v=%b we=%b a=%h d=%h exp 1 1 8 12",
                     ps_req_valid, ps_req_we, ps_req_addr, ps_req_data);
        end
        step(2);
    endtask

    task automatic test_read();
        raddr = 4'hC; arvalid = 1'b1;
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL rd_arready_idle got=%b exp=1", arready);
        end
        step();
        arvalid = 1'b0;
        step();
        checks++;
        if ({ps_req_valid, ps_req_we, ps_req_addr, ps_req_data} !== {1'b1, 1'b0, 4'hC, 32'h0}) begin
            failures++;
            $display("FAIL rd_req got v=%b we=%b a=%h d=%h exp 1 0 c 0",
                     ps_req_valid, ps_req_we, ps_req_addr, ps_req_data);
        end
        step(5);
        ps_rsp_valid = 1'b1; ps_rsp_data = 32'hCAFEF00D;
        checks++;
        if (ps_rsp_ready !== 1'b1 || arready !== 1'b0) begin
            failures++;
            $display("FAIL rd_pending got rsp_rdy=%b arready=%b exp 1 0", ps_rsp_ready, arready);
        end
        step();
        ps_rsp_valid = 1'b0;
        checks++;
        if ({rvalid, rdata, rresp, ps_rsp_ready} !== {1'b1, 32'hCAFEF00D, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL rd_rvalid got rv=%b d=%h resp=%b rsprdy=%b exp 1 cafef00d 00 0",
                     rvalid, rdata, rresp, ps_rsp_ready);
        end
        step();
        checks++;
        if (rvalid !== 1'b1 || arready !== 1'b0) begin
            failures++;
            $display("FAIL rd_hold got rv=%b arready=%b exp 1 0", rvalid, arready);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            failures++;
            $display("FAIL rd_done got rv=%b arready=%b exp 0 1", rvalid, arready);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        ps_req_ready = 1'b0;
        waddr = 4'h1; wdata = 32'hA1; raddr = 4'h2;
        wavalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        wavalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step(3);
        checks++;
        if ({ps_req_we, ps_req_addr, ps_req_data} !== {1'b1, 4'h1, 32'hA1}) begin
            failures++;
            $display("FAIL arb1_first got we=%b a=%h d=%h exp 1 1 a1", ps_req_we, ps_req_addr, ps_req_data);
        end
        ps_req_ready = 1'b1;
        step();
        ps_req_ready = 1'b0;
        checks++;
        if ({ps_req_valid, ps_req_we, ps_req_addr} !== {1'b1, 1'b0, 4'h2}) begin
            failures++;
            $display("FAIL arb1_second got v=%b we=%b a=%h exp 1 0 2", ps_req_valid, ps_req_we, ps_req_addr);
        end
        ps_req_ready = 1'b1;
        ps_rsp_valid = 1'b1; ps_rsp_data = 32'h77;
        step();
        ps_rsp_valid = 1'b0; rready = 1'b1;
        step();
        rready = 1'b0;
        // Lone write leaves the write side as most recent grant.
        waddr = 4'h3; wdata = 32'hB3; wavalid = 1'b1; wvalid = 1'b1;
        step();
        wavalid = 1'b0; wvalid = 1'b0;
        step(3);
        ps_req_ready = 1'b0;
        waddr = 4'h5; wdata = 32'hC5; raddr = 4'h6;
        wavalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        wavalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step(3);
        checks++;
        if ({ps_req_valid, ps_req_we, ps_req_addr} !== {1'b1, 1'b0, 4'h6}) begin
            failures++;
            $display("FAIL arb2_first got v=%b we=%b a=%h exp 1 0 6", ps_req_valid, ps_req_we, ps_req_addr);
        end
        ps_req_ready = 1'b1;
        step();
        checks++;
        if ({ps_req_valid, ps_req_we, ps_req_addr, ps_req_data} !== {1'b1, 1'b1, 4'h5, 32'hC5}) begin
            failures++;
            $display("FAIL arb2_second got v=%b we=%b a=%h d=%h exp 1 1 5 c5",
                     ps_req_valid, ps_req_we, ps_req_addr, ps_req_data);
        end
        step();
        ps_rsp_valid = 1'b1; ps_rsp_data = 32'h88;
        step();
        ps_rsp_valid = 1'b0; rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [31:0] exp_d;
        ps_req_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            waddr = 4'(i); wdata = 32'h100 + 32'(i); wavalid = 1'b1; wvalid = 1'b1;
            step();
            wavalid = 1'b0; wvalid = 1'b0;
            step();
        end
        waddr = 4'hF; wdata = 32'h1FF; wavalid = 1'b1; wvalid = 1'b1;
        step();
        wavalid = 1'b0; wvalid = 1'b0;
        step(3);
        checks++;
        if ({waready, wready, bvalid} !== 3'b000) begin
            failures++;
            $display("FAIL full_blocked got awrdy=%b wrdy=%b b=%b exp 0 0 0", waready, wready, bvalid);
        end
        checks++;
        if (ps_req_data !== 32'h100) begin
            failures++;
            $display("FAIL full_head got=%h exp=00000100", ps_req_data);
        end
        ps_req_ready = 1'b1;
        step();
        ps_req_ready = 1'b0;
        checks++;
        if (waready !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_cycle got awrdy=%b exp 0", waready);
        end
        step();
        checks++;
        if (waready !== 1'b1 || bvalid !== 1'b1) begin
            failures++;
            $display("FAIL full_pushed got awrdy=%b b=%b exp 1 1", waready, bvalid);
        end
        ps_req_ready = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            exp_d = (i < 64) ? 32'h100 + 32'(i) : 32'h1FF;
            checks++;
            if (ps_req_valid !== 1'b1 || ps_req_data !== exp_d) begin
                failures++;
                $display("FAIL drain_%0d got v=%b d=%h exp 1 %h", i, ps_req_valid, ps_req_data, exp_d);
            end
            step();
        end
        checks++;
        if (ps_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got v=%b exp 0", ps_req_valid);
        end
    endtask

    task automatic test_reset_midflight();
        bready = 1'b0; rready = 1'b0; ps_req_ready = 1'b1;
        waddr = 4'h9; wdata = 32'h99; raddr = 4'hA;
        wavalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        wavalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step(4);
        ps_rsp_valid = 1'b1; ps_rsp_data = 32'h5A5A5A5A;
        step();
        ps_rsp_valid = 1'b0;
        ps_req_ready = 1'b0;
        waddr = 4'hB; wdata = 32'hBB; wavalid = 1'b1; wvalid = 1'b1;
        step();
        wavalid = 1'b0; wvalid = 1'b0;
        step(2);
        checks++;
        if ({bvalid, rvalid, arready, waready, ps_req_valid} !== 5'b11000) begin
            failures++;
            $display("FAIL pre_reset got b=%b rv=%b ardy=%b awrdy=%b v=%b exp 1 1 0 0 0",
                     bvalid, rvalid, arready, waready, ps_req_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({waready, wready, arready, bvalid, rvalid, ps_req_valid, ps_rsp_ready} !== 7'b1110001
            || rdata !== 32'h0) begin
            failures++;
            $display("FAIL midflight_reset got=%b rdata=%h exp 1110001 0",
                     {waready, wready, arready, bvalid, rvalid, ps_req_valid, ps_rsp_ready}, rdata);
        end
        #3 rst_n = 1'b1;
        bready = 1'b1;
        step(3);
        checks++;
        if ({bvalid, rvalid, ps_req_valid} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset got b=%b rv=%b v=%b exp 0 0 0", bvalid, rvalid, ps_req_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read();
        test_arbitration();
        test_fifo_full();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
